// File: rtl/pipe_ex_core.sv
// Four-stage pipelined register-register ALU with regbank and data-memory writeback.
// S1 reads operands (with S3 bypass), S2 computes, S3 writes regbank and Zout, S4 writes mem.
module pipe_ex_core (
    output logic [15:0] Zout,
    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    input  logic [3:0]  rd,
    input  logic [3:0]  func,
    input  logic [7:0]  addr,
    input  logic        clk,
    input  logic        rst
);

    typedef enum logic [3:0] {
        FnAdd  = 4'd0,
        FnSub  = 4'd1,
        FnMul  = 4'd2,
        FnSela = 4'd3,
        FnSelb = 4'd4,
        FnAnd  = 4'd5,
        FnOr   = 4'd6,
        FnXor  = 4'd7,
        FnNega = 4'd8,
        FnNegb = 4'd9,
        FnSra  = 4'd10,
        FnSla  = 4'd11
    } alu_fn_e;

    // Architectural state; deliberately not reset
    logic [15:0] regbank [0:15];
    logic [15:0] mem     [0:255];

    // Stage 1 registers
    logic [15:0] a, b;
    logic [3:0]  func1, rd1;
    logic [7:0]  addr1;
    logic        v1;
    // Stage 2 registers
    logic [15:0] z2;
    logic [3:0]  rd2;
    logic [7:0]  addr2;
    logic        v2;
    // Stage 3 registers (Zout is the stage-3 result)
    logic [7:0]  addr3;
    logic        v3;

    logic [15:0] a_rd, b_rd, alu;

    // Operand read with bypass from the S3 writeback happening on the same edge
    always_comb begin
        a_rd = regbank[rs1];
        b_rd = regbank[rs2];
        if (v2 && (rd2 == rs1)) a_rd = z2;
        if (v2 && (rd2 == rs2)) b_rd = z2;
    end

    // ALU; unsigned, results truncated to 16 bits
    always_comb begin
        alu = 16'h0000;
        case (func1)
            FnAdd:   alu = a + b;
            FnSub:   alu = a - b;
            FnMul:   alu = a * b;
            FnSela:  alu = a;
            FnSelb:  alu = b;
            FnAnd:   alu = a & b;
            FnOr:    alu = a | b;
            FnXor:   alu = a ^ b;
            FnNega:  alu = ~a;
            FnNegb:  alu = ~b;
            FnSra:   alu = a >> 1;
            FnSla:   alu = a << 1;
            default: alu = 16'h0000;
        endcase
    end

    // Pipeline registers and valid chain; reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            func1 <= '0;
            rd1   <= '0;
            addr1 <= '0;
            v1    <= 1'b0;
            z2    <= '0;
            rd2   <= '0;
            addr2 <= '0;
            v2    <= 1'b0;
            Zout  <= '0;
            addr3 <= '0;
            v3    <= 1'b0;
        end else begin
            a     <= a_rd;
            b     <= b_rd;
            func1 <= func;
            rd1   <= rd;
            addr1 <= addr;
            v1    <= 1'b1;
            z2    <= alu;
            rd2   <= rd1;
            addr2 <= addr1;
            v2    <= v1;
            Zout  <= z2;
            addr3 <= addr2;
            v3    <= v2;
        end
    end

    // S3 register writeback, gated by the stage valid bit
    always_ff @(posedge clk) begin
        if (v2) regbank[rd2] <= z2;
    end

    // S4 data-memory store, gated by the stage valid bit
    always_ff @(posedge clk) begin
        if (v3) mem[addr3] <= Zout;
    end

endmodule

// File: tb/tb_pipe_ex_core.sv
// Directed bench for pipe_ex_core with a scoreboard queue of expected results.
module tb_pipe_ex_core;

    logic [15:0] Zout;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        clk, rst;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          chk;
        int          id;
        logic [3:0]  rd;
        logic [7:0]  addr;
        logic [15:0] exp;
    } entry_t;

    entry_t      q[$];
    bit          mem_pending = 0;
    int          mem_id;
    logic [7:0]  mem_addr;
    logic [15:0] mem_exp;

    pipe_ex_core dut (
        .Zout(Zout),
        .rs1 (rs1),
        .rs2 (rs2),
        .rd  (rd),
        .func(func),
        .addr(addr),
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int id, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: got %h expected %h", tag, id, got, exp);
        end
    endtask

    // Drive one instruction for the next edge, then retire whatever the pipeline produced
    task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                         input logic [3:0] f, input logic [7:0] ad, input bit chk,
                         input int id, input logic [15:0] exp);
        entry_t e;
        @(negedge clk);
        rs1 = s1; rs2 = s2; rd = d; func = f; addr = ad;
        e.chk = chk; e.id = id; e.rd = d; e.addr = ad; e.exp = exp;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (mem_pending) begin
            check("mem", mem_id, dut.mem[mem_addr], mem_exp);
            mem_pending = 0;
        end
        if (q.size() == 3) begin
            e = q.pop_front();
            if (e.chk) begin
                check("zout", e.id, Zout, e.exp);
                check("regbank", e.id, dut.regbank[e.rd], e.exp);
                mem_pending = 1;
                mem_id      = e.id;
                mem_addr    = e.addr;
                mem_exp     = e.exp;
            end
        end
    endtask

    task automatic filler(input int n);
        for (int i = 0; i < n; i++) issue(4'd0, 4'd0, 4'd0, 4'd3, 8'd0, 1'b0, 0, 16'h0);
    endtask

    logic [15:0] sweep_exp [0:12];

    initial begin
        sweep_exp = '{16'd6, 16'd3, 16'd2, 16'd7, 16'd5, 16'hFFF9, 16'hFFFC, 16'd3, 16'd12,
                      16'd0, 16'd0, 16'd0, 16'd0};
        rst = 1'b1;
        rs1 = 4'd0; rs2 = 4'd0; rd = 4'd0; func = 4'd3; addr = 8'd0;
        for (int k = 0; k < 16; k++) dut.regbank[k] = 16'(k);
        for (int k = 0; k < 256; k++) dut.mem[k] = 16'hDEAD;
        dut.mem[127] = 16'h5A5A;
        dut.mem[200] = 16'h2222;
        dut.mem[202] = 16'h1111;
        repeat (2) @(posedge clk);
        #1;
        check("reset_zout", 0, Zout, 16'h0000);
        @(posedge clk);
        #2 rst = 1'b0;

        // Spec program: ADD, MUL, SUB with bypass from the ADD
        issue(4'd3, 4'd5, 4'd10, 4'd0, 8'd125, 1'b1, 1, 16'd8);
        issue(4'd3, 4'd8, 4'd12, 4'd2, 8'd126, 1'b1, 2, 16'd24);
        issue(4'd10, 4'd5, 4'd14, 4'd1, 8'd128, 1'b1, 3, 16'd3);

        // func sweep 3..15 on A=6, B=3
        for (int f = 3; f < 16; f++)
            issue(4'd6, 4'd3, 4'd11, 4'(f), 8'(130 + f), 1'b1, 100 + f, sweep_exp[f - 3]);

        // Producer into r1, stale read next cycle, rs2 bypass the cycle after
        issue(4'd2, 4'd4, 4'd1, 4'd0, 8'd150, 1'b1, 4, 16'd6);
        issue(4'd1, 4'd0, 4'd13, 4'd3, 8'd151, 1'b1, 5, 16'd1);
        issue(4'd0, 4'd1, 4'd15, 4'd4, 8'd152, 1'b1, 6, 16'd6);
        filler(4);
        check("mem127_untouched", 0, dut.mem[127], 16'h5A5A);

        // Reset with two instructions in flight
        issue(4'd7, 4'd0, 4'd13, 4'd3, 8'd202, 1'b1, 7, 16'd7);
        issue(4'd3, 4'd3, 4'd9, 4'd0, 8'd200, 1'b1, 8, 16'd6);
        issue(4'd0, 4'd0, 4'd0, 4'd3, 8'd0, 1'b0, 0, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_zout", 0, Zout, 16'h0000);
        q.delete();
        mem_pending = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        filler(4);
        check("discard_mem202", 0, dut.mem[202], 16'h1111);
        check("discard_mem200", 0, dut.mem[200], 16'h2222);
        check("discard_r9", 0, dut.regbank[9], 16'd9);

        // First post-reset op completes normally
        issue(4'd4, 4'd5, 4'd8, 4'd0, 8'd201, 1'b1, 9, 16'd9);
        filler(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
